// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MUL/DIV engine: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, stalling the core while busy and pulsing done with the result.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             div_by_zero
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [2:0] SEL_MUL = 3'b010;
   localparam logic [2:0] SEL_DIV = 3'b011;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // fixed_q holds the multiplicand or divisor; shift_q the multiplier or growing quotient
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               dbz_pend_q, dbz_pend_d;
   logic [WIDTH-1:0]   fixed_q, fixed_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               dbz_q, dbz_d;

   logic             accept;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] final_val;

   assign accept = start && (state_q == IDLE) && !flush &&
                   ((alu_sel == SEL_MUL) || (alu_sel == SEL_DIV));

   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (shift_q[0] ? {1'b0, fixed_q} : {(WIDTH+1){1'b0}});
   assign rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, shift_q[WIDTH-1]};
   assign final_val = is_div_q ? shift_q : acc_q[WIDTH-1:0];

   // Result is shown live during an unflushed DONE cycle, otherwise the last delivered value
   assign busy        = (state_q == BUSY);
   assign stall       = accept || busy;
   assign done        = (state_q == DONE) && !flush;
   assign result      = done ? final_val : result_q;
   assign div_by_zero = done ? dbz_pend_q : dbz_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         dbz_pend_q <= 1'b0;
         fixed_q    <= '0;
         shift_q    <= '0;
         acc_q      <= '0;
         rem_q      <= '0;
         result_q   <= '0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_div_q   <= is_div_d;
         dbz_pend_q <= dbz_pend_d;
         fixed_q    <= fixed_d;
         shift_q    <= shift_d;
         acc_q      <= acc_d;
         rem_q      <= rem_d;
         result_q   <= result_d;
         dbz_q      <= dbz_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      dbz_pend_d = dbz_pend_q;
      fixed_d    = fixed_q;
      shift_d    = shift_q;
      acc_d      = acc_q;
      rem_d      = rem_q;
      result_d   = result;
      dbz_d      = div_by_zero;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d    = '0;
               acc_d    = '0;
               rem_d    = '0;
               is_div_d = (alu_sel == SEL_DIV);
               if (alu_sel == SEL_DIV) begin
                  fixed_d = op_b;
                  if (op_b == '0) begin
                     shift_d    = '1;
                     dbz_pend_d = 1'b1;
                     state_d    = DONE;
                  end else begin
                     shift_d    = op_a;
                     dbz_pend_d = 1'b0;
                     state_d    = BUSY;
                  end
               end else begin
                  fixed_d    = op_a;
                  shift_d    = op_b;
                  dbz_pend_d = 1'b0;
                  state_d    = BUSY;
               end
            end
         end
         BUSY: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (is_div_q) begin
                  if (rem_shift >= {1'b0, fixed_q}) begin
                     rem_d   = rem_shift - {1'b0, fixed_q};
                     shift_d = {shift_q[WIDTH-2:0], 1'b1};
                  end else begin
                     rem_d   = rem_shift;
                     shift_d = {shift_q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
                  shift_d = shift_q >> 1;
               end
               if (cnt_d == LAST_CNT) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
